piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 105 ++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out shifter with load handshake.
//
// Accepts a WIDTH-bit word when idle and shifts it out one bit per enabled
// clock, either LSB-first (MSB_FIRST=0) or MSB-first (MSB_FIRST=1).
// All outputs are decoded from registered state only.
//
// Ports:
//   clk         rising-edge clock
//   clr         synchronous active-high reset
//   pdata       parallel word to serialize
//   load_valid  request to load pdata
//   load_ready  high when a word can be accepted (IDLE)
//   shift_en    advance enable; the current bit is held while low
//   dout        serial data out (0 when idle)
//   dout_valid  dout carries a frame bit
//   busy        a word is being shifted out
//   done        one-cycle pulse following the last bit of a word
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] pdata,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int                 CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Move the register one place toward the output end, zero-filling behind.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // load_ready is 1 throughout IDLE, so load_valid alone accepts.
        if (load_valid) begin
          sreg_d  = pdata;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          sreg_d = shift_once(sreg_q);
          if (cnt_q == LAST) begin
            // Counter parks at 0 rather than wrapping past WIDTH-1.
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign dout_valid = busy;
  // Gate with busy so dout reads 0 in IDLE regardless of register contents.
  assign dout       = busy & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
  assign done       = done_q;

endmodule
